// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR multiply-accumulate stage: one multiplier, one tap per cycle,
// full-width signed result handed to the downstream saturator with valid/ready.
module fir_mac_engine #(
  parameter int TAPS = 16,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int N    = 36,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 coef_we,
  input  logic        [AW-1:0] coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [N-1:0]  out_acc
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                state;
  logic signed [DW-1:0]  x [TAPS];
  logic signed [CW-1:0]  c [TAPS];
  logic signed [N-1:0]   acc;
  logic        [AW-1:0]  tap;

  logic signed [DW+CW-1:0] prod;
  logic signed [N-1:0]     acc_sum;

  // Both operands are signed, so the product is a full signed DW+CW result.
  assign prod    = x[tap] * c[tap];
  assign acc_sum = acc + {{(N-DW-CW){prod[DW+CW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      out_acc   <= '0;
      tap       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      // NOTE: delay line and coefficient bank must read as zero after reset, so they
      // are flops with a reset rather than an unreset RAM.
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      // NOTE: every state register uses <= so all updates see pre-edge values.
      case (state)
        IDLE: begin
          // A write in the same cycle as an accept lands before the first MAC cycle.
          if (coef_we) c[coef_addr] <= coef_wdata;
          if (in_valid) begin
            x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
            acc      <= '0;
            tap      <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          tap <= tap + 1'b1;
          if (tap == AW'(TAPS-1)) begin
            out_acc   <= acc_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: directed scenarios plus random traffic,
// compared every cycle against a transaction-level dot-product model.
module tb_fir_mac_engine;

  localparam int TAPS = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               coef_we = 1'b0;
  logic        [3:0]  coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [35:0] out_acc;

  fir_mac_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sample history, coefficient bank and a busy/age tracker.
  longint x_m [TAPS];
  longint c_m [TAPS];
  bit     m_busy;
  int     m_age;
  longint m_next;
  longint m_out;
  int     edge_cnt = 0;
  bit     accepted;
  longint got_q [$];
  int     acc_edges [$];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      x_m[k] = 0;
      c_m[k] = 0;
    end
    m_busy = 0; m_age = 0; m_next = 0; m_out = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    @(posedge clk); edge_cnt++; #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs, compare outputs with the model, advance model across the edge.
  task automatic cycle(input bit iv, input logic signed [15:0] d, input bit orr,
                       input bit we, input logic [3:0] a, input logic signed [15:0] wd);
    bit exp_ov;
    in_valid = iv; in_data = d; out_ready = orr;
    coef_we = we; coef_addr = a; coef_wdata = wd;
    exp_ov = m_busy && (m_age >= TAPS);
    check("in_ready", in_ready, !m_busy);
    check("out_valid", out_valid, exp_ov);
    check("out_acc", out_acc, exp_ov ? m_next : m_out);
    accepted = 0;
    if (!m_busy) begin
      if (we) c_m[a] = wd;
      if (iv) begin
        for (int k = TAPS-1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = d;
        m_next = 0;
        for (int k = 0; k < TAPS; k++) m_next += x_m[k] * c_m[k];
        m_busy = 1; m_age = 0; accepted = 1;
        acc_edges.push_back(edge_cnt + 1);
      end
    end else if (exp_ov && orr) begin
      got_q.push_back(out_acc);
      m_out = m_next;
      m_busy = 0;
    end else begin
      m_age++;
    end
    @(posedge clk); edge_cnt++; #1;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic signed [15:0] wd);
    cycle(0, '0, 1, 1, a, wd);
  endtask

  task automatic wait_idle(input bit we, input logic [3:0] a, input logic signed [15:0] wd);
    for (int i = 0; i < 60 && m_busy; i++) cycle(0, '0, 1, we, a, wd);
    check("result_timeout", m_busy, 0);
  endtask

  task automatic send(input logic signed [15:0] d);
    accepted = 0;
    for (int i = 0; i < 60 && !accepted; i++) cycle(1, d, 1, 0, '0, '0);
    check("accept_timeout", accepted, 1);
    wait_idle(0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s;
    logic signed [15:0] bb [$];
    model_clear();
    #1;
    do_reset();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_acc", out_acc, 0);

    // Impulse response through c[k]=k+1.
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'(k + 1));
    got_q.delete(); acc_edges.delete();
    send(16'sd1);
    for (int k = 0; k < TAPS; k++) send(16'sd0);
    check("impulse_count", got_q.size(), TAPS + 1);
    for (int k = 0; k <= TAPS && k < got_q.size(); k++)
      check($sformatf("impulse_%0d", k), got_q[k], (k < TAPS) ? k + 1 : 0);

    // Extreme magnitudes.
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), -16'sd32768);
    got_q.delete();
    for (int k = 0; k < TAPS; k++) send(-16'sd32768);
    check("extreme_neg", got_q[TAPS-1], 64'sd17179869184);
    got_q.delete();
    for (int k = 0; k < TAPS; k++) send(16'sd32767);
    check("extreme_pos", got_q[TAPS-1], -64'sd17179344896);

    // Backpressure: in_valid held high, out_ready low until 5 cycles after out_valid.
    got_q.delete(); acc_edges.delete();
    accepted = 0;
    for (int i = 0; i < 60 && !accepted; i++) cycle(1, 16'sd123, 0, 0, '0, '0);
    for (int i = 0; i < 60 && m_age < TAPS + 5; i++) cycle(1, 16'sd77, 0, 0, '0, '0);
    check("bp_still_busy", m_busy, 1);
    for (int i = 0; i < 60 && acc_edges.size() < 2; i++) cycle(1, 16'sd77, 1, 0, '0, '0);
    check("bp_second_accept", acc_edges.size(), 2);
    wait_idle(0, '0, '0);
    check("bp_results", got_q.size(), 2);

    // Coefficient writes during MAC are dropped; in IDLE they apply to the next sample.
    do_reset();
    write_coef(4'd0, 16'sd2);
    write_coef(4'd3, 16'sd7);
    send(16'sd1); send(16'sd1); send(16'sd1);
    got_q.delete();
    accepted = 0;
    for (int i = 0; i < 60 && !accepted; i++) cycle(1, 16'sd9, 1, 0, '0, '0);
    wait_idle(1, 4'd3, 16'sd1000);
    send(16'sd5);
    write_coef(4'd3, 16'sd1000);
    send(16'sd0);
    check("mask_cur", got_q[0], 25);
    check("mask_next", got_q[1], 17);
    check("mask_idle_write", got_q[2], 1000);

    // Reset during MAC aborts the result and clears the delay line and coefficients.
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'sd3);
    send(16'sd40); send(16'sd41);
    accepted = 0;
    for (int i = 0; i < 60 && !accepted; i++) cycle(1, 16'sd50, 1, 0, '0, '0);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0, '0, '0);
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    got_q.delete();
    send(16'sd1);
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'sd1);
    send(16'sd0);
    check("rst_zero_coef", got_q[0], 0);
    check("rst_cleared_line", got_q[1], 1);

    // Back-to-back streaming, one result every TAPS+2 cycles.
    do_reset();
    write_coef(4'd0, 16'sd1);
    got_q.delete(); acc_edges.delete();
    bb = '{16'sd5, -16'sd7, 16'sd100};
    for (int i = 0; i < 200 && (bb.size() > 0 || m_busy); i++) begin
      cycle(bb.size() > 0, (bb.size() > 0) ? bb[0] : 16'sd0, 1, 0, '0, '0);
      if (accepted) void'(bb.pop_front());
    end
    check("b2b_count", got_q.size(), 3);
    check("b2b_0", got_q[0], 5);
    check("b2b_1", got_q[1], -7);
    check("b2b_2", got_q[2], 100);
    check("b2b_period_a", acc_edges[1] - acc_edges[0], TAPS + 2);
    check("b2b_period_b", acc_edges[2] - acc_edges[1], TAPS + 2);

    // Random traffic with random coefficient writes and backpressure.
    for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'($urandom));
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, 4'($urandom), 16'($urandom));
    wait_idle(0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
